// File: rtl/cfg_pkg.sv
// Shared constants and state encodings for the UART configuration writer.
package cfg_pkg;

  // Every frame opens with this byte; it also seeds the checksum.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Frame-level progress through sync, address, data and checksum bytes.
  typedef enum logic [1:0] {
    WAIT_SYNC,
    GET_ADDR,
    GET_DATA,
    GET_CHK
  } byte_st_e;

  // Bit-level UART receiver phases.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } bit_st_e;

  // Bits needed to hold values 0..x.
  function automatic int wd(input int x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, bit engine and bit-period counter.
// Emits one-cycle byte_vld (with byte) or frm_err per received character.
module uart_rx_byte
  import cfg_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       frm_err_o,
  output logic       busy_o
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;
  logic          fall;
  bit_st_e       st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic [7:0]    byte_q;
  logic          byte_vld_q;
  logic          frm_err_q;

  assign rx_s = sync_q[1];
  // A high-to-low step is the only way to start a character, so after a
  // framing error with the line stuck low nothing re-arms until it goes high.
  assign fall = prev_q & ~rx_s;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  // Bit engine: qualify start at mid-bit, then sample every DIV cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (st_q)
        IDLE: begin
          if (fall) begin
            st_q  <= START;
            cnt_q <= CW'(1);
          end
        end
        START: begin
          if (cnt_q == CW'(HALF)) begin
            if (rx_s) begin
              st_q <= IDLE;  // glitch, not a start bit
            end else begin
              st_q  <= DATA;
              cnt_q <= CW'(1);
              idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CW'(DIV)) begin
            sh_q  <= {rx_s, sh_q[7:1]};
            cnt_q <= CW'(1);
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) st_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CW'(DIV)) begin
            st_q <= IDLE;
            if (rx_s) begin
              byte_vld_q <= 1'b1;
              byte_q     <= sh_q;
            end else begin
              frm_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign byte_vld_o = byte_vld_q;
  assign byte_o     = byte_q;
  assign frm_err_o  = frm_err_q;
  assign busy_o     = (st_q != IDLE);

endmodule

// File: rtl/cfg_uart_writer.sv
// Host configuration master: decodes A5/addr/data/checksum UART frames and
// drives a single-cycle register-write strobe for every valid frame.
module cfg_uart_writer
  import cfg_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_MAX     = 4,
  parameter int DATA_MAX     = 255,
  parameter int TIMEOUT_BITS = 20,
  localparam int AW          = wd(ADDR_MAX),
  localparam int DW          = wd(DATA_MAX)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          en_o,
  output logic          err_o
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TMO = TIMEOUT_BITS * DIV;
  localparam int TW  = $clog2(TMO + 1);

  logic          byte_vld;
  logic [7:0]    rx_byte;
  logic          frm_err;
  logic          busy;

  byte_st_e      st_q;
  logic [7:0]    addr_tmp_q;
  logic [7:0]    data_tmp_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          en_q;
  logic          err_q;
  logic [TW-1:0] tmo_q;

  logic [7:0]    chk_exp;
  logic          frame_ok;
  logic          tmo_hit;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .byte_vld_o (byte_vld),
    .byte_o     (rx_byte),
    .frm_err_o  (frm_err),
    .busy_o     (busy)
  );

  // Checksum is the 8-bit wrapping sum of sync, address and data.
  assign chk_exp  = SYNC_BYTE + addr_tmp_q + data_tmp_q;
  // One spare bit keeps the range compares from degenerating at full scale.
  assign frame_ok = (rx_byte == chk_exp)
                 && ({1'b0, addr_tmp_q} <= 9'(ADDR_MAX))
                 && ({1'b0, data_tmp_q} <= 9'(DATA_MAX));
  assign tmo_hit  = (tmo_q == TW'(TMO - 1));

  // Byte FSM with idle timeout; en/err are mutually exclusive by priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= WAIT_SYNC;
      addr_tmp_q <= '0;
      data_tmp_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      if (frm_err) begin
        err_q <= 1'b1;
        st_q  <= WAIT_SYNC;
        tmo_q <= '0;
      end else if (byte_vld) begin
        tmo_q <= '0;
        case (st_q)
          WAIT_SYNC: if (rx_byte == SYNC_BYTE) st_q <= GET_ADDR;
          GET_ADDR: begin
            addr_tmp_q <= rx_byte;
            st_q       <= GET_DATA;
          end
          GET_DATA: begin
            data_tmp_q <= rx_byte;
            st_q       <= GET_CHK;
          end
          GET_CHK: begin
            if (frame_ok) begin
              addr_q <= addr_tmp_q[AW-1:0];
              data_q <= data_tmp_q[DW-1:0];
              en_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            st_q <= WAIT_SYNC;
          end
          default: st_q <= WAIT_SYNC;
        endcase
      end else if (st_q == WAIT_SYNC || busy) begin
        tmo_q <= '0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
        st_q  <= WAIT_SYNC;
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;
  assign en_o   = en_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_cfg_uart_writer.sv
// Self-checking bench for cfg_uart_writer at DIV=10.
module tb_cfg_uart_writer;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [2:0] addr;
  logic [7:0] data;
  logic       en;
  logic       err;

  always #5 clk = ~clk;

  cfg_uart_writer #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .ADDR_MAX     (4),
    .DATA_MAX     (255),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .addr_o (addr),
    .data_o (data),
    .en_o   (en),
    .err_o  (err)
  );

  typedef struct {
    string      name;
    int         noise;
    logic [7:0] a, d, c;
    int         exp_en, exp_err;
    logic [2:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  int checks = 0, errors = 0;
  int en_cnt = 0, err_cnt = 0, both_cnt = 0;
  int cyc = 0, en_cyc = 0, stop_cyc = 0;
  logic [10:0] enq[$];
  logic [2:0]  m_addr;
  logic [7:0]  m_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (en) begin
      en_cnt++;
      en_cyc = cyc;
      enq.push_back({addr, data});
    end
    if (err) err_cnt++;
    if (en && err) both_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    stop_cyc = cyc;
    rx = stopb;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic run_frame(input string nm, input int noise, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] c,
                           input int exp_en, input int exp_err,
                           input logic [2:0] ea, input logic [7:0] ed);
    int e0, r0, lat;
    e0 = en_cnt;
    r0 = err_cnt;
    if (noise != 0) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(c, 1'b1);
    repeat (6) @(negedge clk);
    chk({nm, " en"}, en_cnt - e0, exp_en);
    chk({nm, " err"}, err_cnt - r0, exp_err);
    chk({nm, " addr"}, {29'd0, addr}, {29'd0, ea});
    chk({nm, " data"}, {24'd0, data}, {24'd0, ed});
    if (exp_en == 1) begin
      lat = en_cyc - stop_cyc;
      chk({nm, " latency_ok"}, {31'd0, (lat >= 6 && lat <= 12)}, 1);
    end
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0;
    vecs[0] = '{"good",     0, 8'h02, 8'h40, 8'hE7, 1, 0, 3'd2, 8'h40};
    vecs[1] = '{"bad_chk",  0, 8'h01, 8'h10, 8'h00, 0, 1, 3'd2, 8'h40};
    vecs[2] = '{"good2",    0, 8'h01, 8'h10, 8'hB6, 1, 0, 3'd1, 8'h10};
    vecs[3] = '{"range",    0, 8'h07, 8'h01, 8'hAD, 0, 1, 3'd1, 8'h10};
    vecs[4] = '{"noise",    1, 8'h03, 8'h05, 8'hAD, 1, 0, 3'd3, 8'h05};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst addr", {29'd0, addr}, 0);
    chk("rst data", {24'd0, data}, 0);
    chk("rst en", {31'd0, en}, 0);
    chk("rst err", {31'd0, err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].name, vecs[i].noise, vecs[i].a, vecs[i].d, vecs[i].c,
                vecs[i].exp_en, vecs[i].exp_err, vecs[i].exp_addr, vecs[i].exp_data);

    // Stop bit low in the address byte.
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b0);
    repeat (20) @(negedge clk);
    chk("frm err", err_cnt - r0, 1);
    chk("frm en", en_cnt - e0, 0);
    run_frame("post_frm", 0, 8'h04, 8'h11, 8'hBA, 1, 0, 3'd4, 8'h11);

    // Short low glitch on the idle line.
    e0 = en_cnt; r0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch err", err_cnt - r0, 0);
    chk("glitch en", en_cnt - e0, 0);
    run_frame("post_glitch", 0, 8'h00, 8'h33, 8'hD8, 1, 0, 3'd0, 8'h33);

    // Stall after the address byte.
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (250) @(negedge clk);
    chk("tmo err", err_cnt - r0, 1);
    chk("tmo en", en_cnt - e0, 0);
    run_frame("post_tmo", 0, 8'h01, 8'h22, 8'hC8, 1, 0, 3'd1, 8'h22);

    // Reset in the middle of the data byte.
    r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst addr", {29'd0, addr}, 0);
    chk("arst data", {24'd0, data}, 0);
    chk("arst en", {31'd0, en}, 0);
    chk("arst err", {31'd0, err}, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst no err", err_cnt - r0, 0);

    // Two frames with no idle gap between them.
    enq.delete();
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'hFF, 1'b1); send_byte(8'hA8, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'hA5, 1'b1);
    repeat (6) @(negedge clk);
    chk("b2b en", en_cnt - e0, 2);
    chk("b2b err", err_cnt - r0, 0);
    chk("b2b n", enq.size(), 2);
    if (enq.size() == 2) begin
      chk("b2b first", {21'd0, enq[0]}, {21'd0, 3'd4, 8'hFF});
      chk("b2b second", {21'd0, enq[1]}, 0);
    end

    // Randomised frames against a frame-level model.
    m_addr = 3'd0;
    m_data = 8'h00;
    for (int n = 0; n < 25; n++) begin
      logic [7:0] a, d, c, nb;
      int ok;
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) c = 8'((165 + a + d) % 256);
      else                           c = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb, 1'b1);
      end
      ok = (int'(c) == (165 + int'(a) + int'(d)) % 256) && (a <= 8'd4);
      if (ok != 0) begin
        m_addr = a[2:0];
        m_data = d;
      end
      run_frame($sformatf("rnd%0d", n), 0, a, d, c,
                (ok != 0) ? 1 : 0, (ok != 0) ? 0 : 1, m_addr, m_data);
    end

    chk("en_err_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_uart_writer.md
Name: cfg_uart_writer

Overview:
- Host-side configuration master for the controller's register-write bus (addr/data/en), the interface that the phase-shift predictor and other tunable blocks respond to.
- Receives framed UART bytes from an external host: sync, address, data, checksum.
- Validates each frame and issues exactly one single-cycle write strobe per good frame; bad frames are dropped and flagged.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD (integer division), must be >= 8
ADDR_MAX, 4, highest legal register address; addr width AW = $clog2(ADDR_MAX+1)
DATA_MAX, 255, largest data value; data width DW = $clog2(DATA_MAX+1), must be <= 8
TIMEOUT_BITS, 20, inter-byte idle limit in bit-times before the frame is abandoned

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  UART line, idle high, asynchronous to clk
addr  out  AW  register address of last accepted write
data  out  DW  register data of last accepted write
en  out  1  one-cycle write strobe; addr/data are valid in the same cycle
err  out  1  one-cycle pulse on framing, checksum, range or timeout error

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: addr=0, data=0, en=0, err=0; rx synchroniser flops = 1; byte FSM = WAIT_SYNC; bit engine = IDLE.
- Reset mid-frame aborts the frame silently, with no err pulse.
- rx passes through a 2-flop synchroniser (2-cycle latency) before any use.
- Bit engine states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - START is entered on a synchronised falling edge. rx is re-checked at DIV/2; if high, it is a glitch: return to IDLE with no error.
  - Bits are sampled every DIV cycles after the start mid-point.
  - STOP is sampled once. If 0, it is a framing error: pulse err, discard the byte, and wait for rx high before re-arming.
  - A valid stop bit emits byte_vld for one cycle, together with an 8-bit byte.
- Byte FSM:
  - WAIT_SYNC: byte 0xA5 -> GET_ADDR; any other byte is ignored silently.
  - GET_ADDR: latch the byte as addr_tmp -> GET_DATA.
  - GET_DATA: latch the byte as data_tmp -> GET_CHK.
  - GET_CHK: good frame when byte == (0xA5 + addr_tmp + data_tmp) mod 256, addr_tmp <= ADDR_MAX and data_tmp <= DATA_MAX. On a good frame, load addr/data and pulse en. Otherwise pulse err; addr/data are unchanged. Always -> WAIT_SYNC.
- Latency: en and addr/data update in the cycle after the checksum byte's byte_vld. addr/data hold their values until the next good frame.
- Timeout: in GET_ADDR, GET_DATA or GET_CHK, an idle counter runs while the bit engine is IDLE and clears on each start edge. Reaching TIMEOUT_BITS*DIV cycles pulses err and returns to WAIT_SYNC.
- A framing error in any byte state pulses err and forces WAIT_SYNC; only one err pulse is issued per event.
- en and err are never asserted in the same cycle. Back-to-back frames with no idle gap must each produce en.

Decomposition:
- Package cfg_pkg:
  - SYNC_BYTE = 8'hA5
  - byte-FSM state enum {WAIT_SYNC, GET_ADDR, GET_DATA, GET_CHK}
  - bit-engine state enum {IDLE, START, DATA, STOP}
  - width helper function wd(x) = $clog2(x+1)
- One sub-module, uart_rx_byte:
  - contains the synchroniser, bit engine and DIV counter
  - outputs byte_vld, byte and frm_err
- The top level holds the byte FSM, checksum, range check and timeout counter.

Test Plan:
All scenarios use CLK_HZ=1_000_000 and BAUD=100_000 (DIV=10) with defaults otherwise.
1. Good frame: A5 02 40 E7 -> en pulses once, addr=2, data=0x40, err stays 0. en rises within 2 cycles after the checksum stop-bit sample.
2. Bad checksum: A5 01 10 00 -> err pulses once, no en, addr/data keep prior values. A following A5 01 10 B6 -> en, addr=1, data=0x10.
3. Out of range: A5 07 01 AD (addr 7 > 4) -> err pulses, no en. Leading noise 00 FF before A5 03 05 AD -> no err from the noise, en with addr=3, data=5.
4. Framing and glitch: stop bit driven low in the addr byte -> err, FSM back to WAIT_SYNC. A 3-cycle low glitch on idle rx -> no byte, no err.
5. Timeout: send A5 02, then hold idle for 200+ cycles -> err pulse, state WAIT_SYNC. A subsequent full good frame -> en.
6. Reset and throughput: rst_n low mid-data-byte -> outputs return to 0 immediately (asynchronously), no err. Afterwards, two back-to-back good frames (addr 4 data 0xFF, then addr 0 data 0x00) -> two en pulses, each with correct values.
